retire_trace_serializer: RTL and testbench

Consumes the per-retirement trace port driven by the RV32I pipelined core (`update`, `pc`, `instr`, `reg_addr`, `reg_data`, `mem_addr`, `mem_data`, `mem_wrt`). It buffers records in a small synchronous FIFO and serializes each record as a framed byte stream over a valid/ready interface toward a UART bridge or log sink. If the FIFO is full, the incoming record is dropped and counted. The next record that is stored is flagged so that gaps are visible downstream.

---
 rtl/riscv_pkg.sv | 66 ++++++
 rtl/trace_fifo.sv | 70 +++++++
 rtl/retire_trace_serializer.sv | 144 ++++++++++++++
 tb/tb_retire_trace_serializer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the retirement trace path: frame constants, the
// buffered record layout, serializer states and the frame byte selector.
package riscv_pkg;

   localparam logic [7:0] TRACE_SYNC     = 8'hA5;
   localparam int         TRACE_LEN_BASE = 14;
   localparam int         TRACE_LEN_MEM  = 22;

   // One retired instruction as held in the trace FIFO and the frame register.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [4:0]  reg_addr;
      logic [31:0] reg_data;
      logic [31:0] mem_addr;
      logic [31:0] mem_data;
      logic        mem_wrt;
      logic        ovf;
   } trace_rec_t;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } trace_state_e;

   // Index of the final byte of a frame; stores carry two extra words.
   function automatic logic [4:0] trace_last_idx(input logic mem_wrt);
      return mem_wrt ? 5'(TRACE_LEN_MEM - 1) : 5'(TRACE_LEN_BASE - 1);
   endfunction

   // Byte at position idx of the frame built from rec. Words go out
   // little-endian; positions past the frame end read as zero.
   function automatic logic [7:0] trace_byte(input trace_rec_t rec, input logic [4:0] idx);
      logic [7:0]  b;
      logic [31:0] w;
      logic [1:0]  lane;
      b    = 8'h00;
      w    = 32'h0;
      lane = 2'd0;
      if (idx == 5'd0) begin
         b = TRACE_SYNC;
      end else if (idx == 5'd1) begin
         b = {rec.mem_wrt, rec.ovf, 1'b0, rec.reg_addr};
      end else begin
         if (idx < 5'd6) begin
            w    = rec.pc;
            lane = 2'(idx - 5'd2);
         end else if (idx < 5'd10) begin
            w    = rec.instr;
            lane = 2'(idx - 5'd6);
         end else if (idx < 5'd14) begin
            w    = rec.reg_data;
            lane = 2'(idx - 5'd10);
         end else if (idx < 5'd18) begin
            w    = rec.mem_addr;
            lane = 2'(idx - 5'd14);
         end else if (idx < 5'd22) begin
            w    = rec.mem_data;
            lane = 2'(idx - 5'd18);
         end
         b = w[lane*8 +: 8];
      end
      return b;
   endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO with a combinational head read. A push while full and a
// pop while empty are ignored, so callers may gate or not as they see fit.
module trace_fifo
   import riscv_pkg::*;
#(
   parameter int  DEPTH   = 8,
   parameter type entry_t = trace_rec_t
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  entry_t                   wdata_i,
   input  logic                     pop_i,
   output entry_t                   rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int AW = $clog2(DEPTH);

   entry_t        mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   level_q, level_d;
   logic          do_push, do_pop;

   // Pointer and occupancy update; pointers wrap naturally since DEPTH is 2^AW.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      do_push  = push_i && !full_o;
      do_pop   = pop_i && !empty_o;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   // Control state register.
   always_ff @(posedge clk_i) begin
      // NOTE: sequential state is written with <= so every flop samples pre-edge values.
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Entry storage.
   always_ff @(posedge clk_i) begin
      // NOTE: storage is not reset; the level counter alone decides which entries are meaningful.
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign full_o  = (level_q == (AW+1)'(DEPTH));
   assign empty_o = (level_q == '0);
   assign level_o = level_q;

endmodule

// File: rtl/retire_trace_serializer.sv
// Captures core retirement records into a FIFO and streams each one as a
// framed byte sequence over valid/ready. Records arriving while the FIFO is
// full are dropped, counted, and flagged on the next record that gets in.
module retire_trace_serializer
   import riscv_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int DROP_W = 16
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      update_i,
   input  logic [31:0]               pc_i,
   input  logic [31:0]               instr_i,
   input  logic [4:0]                reg_addr_i,
   input  logic [31:0]               reg_data_i,
   input  logic [31:0]               mem_addr_i,
   input  logic [31:0]               mem_data_i,
   input  logic                      mem_wrt_i,
   output logic [7:0]                tx_data_o,
   output logic                      tx_valid_o,
   input  logic                      tx_ready_i,
   output logic [$clog2(DEPTH):0]    fifo_level_o,
   output logic [DROP_W-1:0]         drop_cnt_o,
   output logic                      busy_o
);

   trace_rec_t        push_rec;
   trace_rec_t        head_rec;
   logic              fifo_full, fifo_empty;
   logic              do_push, do_drop, do_pop;

   trace_state_e      state_q, state_d;
   trace_rec_t        frame_q, frame_d;
   logic [4:0]        idx_q, idx_d;
   logic              ovf_q, ovf_d;
   logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
   logic              last_byte;

   trace_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (trace_rec_t)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (do_push),
      .wdata_i (push_rec),
      .pop_i   (do_pop),
      .rdata_o (head_rec),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (fifo_level_o)
   );

   // Capture: push when there is room, otherwise drop, count and flag the gap.
   // Fullness is the pre-edge value, so a same-edge pop does not rescue a push.
   always_comb begin
      do_push           = update_i && !fifo_full;
      do_drop           = update_i && fifo_full;
      push_rec          = '0;
      push_rec.pc       = pc_i;
      push_rec.instr    = instr_i;
      push_rec.reg_addr = reg_addr_i;
      push_rec.reg_data = reg_data_i;
      push_rec.mem_addr = mem_addr_i;
      push_rec.mem_data = mem_data_i;
      push_rec.mem_wrt  = mem_wrt_i;
      push_rec.ovf      = ovf_q;
      ovf_d             = ovf_q;
      drop_cnt_d        = drop_cnt_q;
      if (do_push) begin
         ovf_d = 1'b0;
      end else if (do_drop) begin
         ovf_d = 1'b1;
         if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
      end
   end

   // Serializer next state: load a frame from the FIFO head, step the byte
   // index on each accepted byte, and chain straight into the next frame.
   always_comb begin
      state_d    = state_q;
      frame_d    = frame_q;
      idx_d      = idx_q;
      do_pop     = 1'b0;
      tx_valid_o = 1'b0;
      last_byte  = (idx_q == trace_last_idx(frame_q.mem_wrt));
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               do_pop  = 1'b1;
               frame_d = head_rec;
               idx_d   = 5'd0;
               state_d = SEND;
            end
         end
         SEND: begin
            tx_valid_o = 1'b1;
            if (tx_ready_i) begin
               if (last_byte) begin
                  idx_d = 5'd0;
                  if (!fifo_empty) begin
                     do_pop  = 1'b1;
                     frame_d = head_rec;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  idx_d = idx_q + 5'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Byte output: held steady while stalled because frame and index only
   // move on acceptance; idle drives zero.
   always_comb begin
      tx_data_o = 8'h00;
      if (tx_valid_o) tx_data_o = trace_byte(frame_q, idx_q);
   end

   // State registers for the serializer and the drop bookkeeping.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         frame_q    <= '0;
         idx_q      <= 5'd0;
         ovf_q      <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         frame_q    <= frame_d;
         idx_q      <= idx_d;
         ovf_q      <= ovf_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign drop_cnt_o = drop_cnt_q;
   assign busy_o     = (state_q == SEND) || !fifo_empty;

endmodule

// File: tb/tb_retire_trace_serializer.sv
// Directed bench for retire_trace_serializer: reset state, frame contents,
// latency, backpressure hold, back-to-back streaming, overflow and reset.
module tb_retire_trace_serializer;

   typedef logic [7:0] byte_q_t [$];

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        update_i;
   logic [31:0] pc_i, instr_i, reg_data_i, mem_addr_i, mem_data_i;
   logic [4:0]  reg_addr_i;
   logic        mem_wrt_i;
   logic [7:0]  tx_data_o;
   logic        tx_valid_o;
   logic        tx_ready_i;
   logic [3:0]  fifo_level_o;
   logic [15:0] drop_cnt_o;
   logic        busy_o;

   int total = 0;
   int bad   = 0;

   // Monitor state: captured stream and stall-hold violations.
   logic [7:0] rx_q [$];
   logic       held = 1'b0;
   logic [7:0] held_data = 8'h00;
   int         hold_err = 0;
   int         rx_start = 0;

   retire_trace_serializer #(.DEPTH(8), .DROP_W(16)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .update_i     (update_i),
      .pc_i         (pc_i),
      .instr_i      (instr_i),
      .reg_addr_i   (reg_addr_i),
      .reg_data_i   (reg_data_i),
      .mem_addr_i   (mem_addr_i),
      .mem_data_i   (mem_data_i),
      .mem_wrt_i    (mem_wrt_i),
      .tx_data_o    (tx_data_o),
      .tx_valid_o   (tx_valid_o),
      .tx_ready_i   (tx_ready_i),
      .fifo_level_o (fifo_level_o),
      .drop_cnt_o   (drop_cnt_o),
      .busy_o       (busy_o)
   );

   always #5 clk_i = ~clk_i;

   // Sample on the falling edge: log accepted bytes, verify stalled bytes hold.
   always @(negedge clk_i) begin
      if (rst_i) begin
         held = 1'b0;
      end else begin
         if (held && (!tx_valid_o || tx_data_o != held_data)) hold_err++;
         if (tx_valid_o && !tx_ready_i) begin
            held      = 1'b1;
            held_data = tx_data_o;
         end else begin
            held = 1'b0;
         end
         if (tx_valid_o && tx_ready_i) rx_q.push_back(tx_data_o);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   function automatic int rx_n();
      return rx_q.size() - rx_start;
   endfunction

   function automatic logic [7:0] rx_at(input int i);
      return rx_q[rx_start + i];
   endfunction

   function automatic byte_q_t make_frame(input logic [31:0] pc, input logic [31:0] instr,
                                          input logic [4:0] ra, input logic [31:0] rd,
                                          input logic [31:0] ma, input logic [31:0] md,
                                          input logic mw, input logic ovf);
      byte_q_t f;
      f.push_back(8'hA5);
      f.push_back({mw, ovf, 1'b0, ra});
      for (int i = 0; i < 4; i++) f.push_back(pc[8*i +: 8]);
      for (int i = 0; i < 4; i++) f.push_back(instr[8*i +: 8]);
      for (int i = 0; i < 4; i++) f.push_back(rd[8*i +: 8]);
      if (mw) begin
         for (int i = 0; i < 4; i++) f.push_back(ma[8*i +: 8]);
         for (int i = 0; i < 4; i++) f.push_back(md[8*i +: 8]);
      end
      return f;
   endfunction

   task automatic cmp_frame(input string tag, input byte_q_t exp);
      check({tag, "_len"}, rx_n(), exp.size());
      for (int i = 0; i < exp.size(); i++) check($sformatf("%s[%0d]", tag, i), rx_at(i), exp[i]);
   endtask

   task automatic set_rec(input logic [31:0] pc, input logic [31:0] instr, input logic [4:0] ra,
                          input logic [31:0] rd, input logic [31:0] ma, input logic [31:0] md,
                          input logic mw);
      pc_i       = pc;
      instr_i    = instr;
      reg_addr_i = ra;
      reg_data_i = rd;
      mem_addr_i = ma;
      mem_data_i = md;
      mem_wrt_i  = mw;
   endtask

   task automatic push_rec(input logic [31:0] pc, input logic [31:0] instr, input logic [4:0] ra,
                           input logic [31:0] rd, input logic [31:0] ma, input logic [31:0] md,
                           input logic mw);
      set_rec(pc, instr, ra, rd, ma, md, mw);
      update_i = 1'b1;
      step();
      update_i = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n = 0;
      while ((tx_valid_o || busy_o) && n < budget) begin
         step();
         n++;
      end
      if (n >= budget) check({tag, "_timeout"}, 32'd1, 32'd0);
   endtask

   initial begin
      byte_q_t e;
      int      cnt;

      rst_i      = 1'b1;
      update_i   = 1'b0;
      tx_ready_i = 1'b0;
      set_rec(32'h0, 32'h0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0);
      step();
      step();
      check("rst_valid", tx_valid_o, 0);
      check("rst_data", tx_data_o, 0);
      check("rst_level", fifo_level_o, 0);
      check("rst_drop", drop_cnt_o, 0);
      check("rst_busy", busy_o, 0);
      rst_i = 1'b0;
      step();

      // Single record, no memory write: latency and 14-cycle frame.
      tx_ready_i = 1'b1;
      rx_start   = rx_q.size();
      push_rec(32'h0000_0010, 32'h0050_0093, 5'd1, 32'd5, 32'h0, 32'h0, 1'b0);
      check("lat_valid_n", tx_valid_o, 0);
      check("lat_level_n", fifo_level_o, 1);
      check("lat_busy_n", busy_o, 1);
      step();
      check("lat_valid_n1", tx_valid_o, 1);
      check("lat_sync_n1", tx_data_o, 8'hA5);
      check("lat_level_n1", fifo_level_o, 0);
      cnt = 0;
      while (tx_valid_o && cnt < 40) begin
         cnt++;
         step();
      end
      check("single_cycles", cnt, 14);
      e = '{8'hA5, 8'h01, 8'h10, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
            8'h05, 8'h00, 8'h00, 8'h00};
      cmp_frame("single", e);
      check("single_busy_end", busy_o, 0);

      // Store record: flags 0x80, 22 bytes ending in mem_data little-endian.
      rx_start = rx_q.size();
      push_rec(32'h0000_0020, 32'h0010_2023, 5'd0, 32'h0, 32'h0000_0100, 32'hDEAD_BEEF, 1'b1);
      wait_idle("store", 60);
      check("store_len", rx_n(), 22);
      check("store_flags", rx_at(1), 8'h80);
      check("store_b18", rx_at(18), 8'hEF);
      check("store_b19", rx_at(19), 8'hBE);
      check("store_b20", rx_at(20), 8'hAD);
      check("store_b21", rx_at(21), 8'hDE);
      check("store_b14", rx_at(14), 8'h00);
      check("store_b15", rx_at(15), 8'h01);

      // Backpressure: random ready pattern, sequence and held bytes unchanged.
      tx_ready_i = 1'b0;
      rx_start   = rx_q.size();
      push_rec(32'h1234_5678, 32'hCAFE_BABE, 5'd7, 32'h89AB_CDEF, 32'h0000_0200, 32'h0102_0304, 1'b1);
      cnt = 0;
      while ((tx_valid_o || busy_o) && cnt < 400) begin
         tx_ready_i = 1'($urandom_range(0, 1));
         step();
         cnt++;
      end
      if (cnt >= 400) check("bp_timeout", 32'd1, 32'd0);
      tx_ready_i = 1'b1;
      e = make_frame(32'h1234_5678, 32'hCAFE_BABE, 5'd7, 32'h89AB_CDEF, 32'h0000_0200, 32'h0102_0304,
                     1'b1, 1'b0);
      cmp_frame("bp", e);
      check("bp_hold_err", hold_err, 0);

      // Back-to-back: three queued frames stream as 42 contiguous valid cycles.
      tx_ready_i = 1'b0;
      rx_start   = rx_q.size();
      push_rec(32'h0000_0100, 32'h0000_0013, 5'd2, 32'h0000_0011, 32'h0, 32'h0, 1'b0);
      push_rec(32'h0000_0104, 32'h0000_0033, 5'd3, 32'h0000_0022, 32'h0, 32'h0, 1'b0);
      push_rec(32'h0000_0108, 32'h0000_0063, 5'd4, 32'h0000_0033, 32'h0, 32'h0, 1'b0);
      check("b2b_level", fifo_level_o, 2);
      tx_ready_i = 1'b1;
      cnt = 0;
      while (tx_valid_o && cnt < 100) begin
         cnt++;
         step();
      end
      check("b2b_cycles", cnt, 42);
      e = make_frame(32'h0000_0100, 32'h0000_0013, 5'd2, 32'h0000_0011, 32'h0, 32'h0, 1'b0, 1'b0);
      e = {e, make_frame(32'h0000_0104, 32'h0000_0033, 5'd3, 32'h0000_0022, 32'h0, 32'h0, 1'b0, 1'b0)};
      e = {e, make_frame(32'h0000_0108, 32'h0000_0063, 5'd4, 32'h0000_0033, 32'h0, 32'h0, 1'b0, 1'b0)};
      cmp_frame("b2b", e);

      // Overflow: one frame in flight, then 10 updates into an 8-deep FIFO.
      tx_ready_i = 1'b0;
      push_rec(32'h0000_0200, 32'h0000_0013, 5'd1, 32'h1, 32'h0, 32'h0, 1'b0);
      step();
      check("ovf_inflight", tx_valid_o, 1);
      check("ovf_level0", fifo_level_o, 0);
      for (int i = 0; i < 10; i++) begin
         set_rec(32'h0000_1000 + 32'(4 * i), 32'h0000_0013, 5'd5, 32'(i), 32'h0, 32'h0, 1'b0);
         update_i = 1'b1;
         step();
         if (i == 7) check("ovf_level_at8", fifo_level_o, 8);
         if (i == 8) check("ovf_drop_at9", drop_cnt_o, 1);
      end
      update_i = 1'b0;
      check("ovf_level", fifo_level_o, 8);
      check("ovf_drop", drop_cnt_o, 2);
      tx_ready_i = 1'b1;
      rx_start   = rx_q.size();
      wait_idle("ovf_drain", 400);
      check("ovf_drain_bytes", rx_n(), 9 * 14);
      check("ovf_last_pc0", rx_at(8 * 14 + 2), 8'h1C);
      check("ovf_hold_err", hold_err, 0);
      rx_start = rx_q.size();
      push_rec(32'h0000_0300, 32'h0000_0013, 5'd3, 32'h0000_0077, 32'h0, 32'h0, 1'b0);
      wait_idle("ovf_next", 60);
      check("ovf_flag_set", rx_at(1), 8'h43);
      e = make_frame(32'h0000_0300, 32'h0000_0013, 5'd3, 32'h0000_0077, 32'h0, 32'h0, 1'b0, 1'b1);
      cmp_frame("ovf_next", e);
      rx_start = rx_q.size();
      push_rec(32'h0000_0304, 32'h0000_0013, 5'd3, 32'h0000_0078, 32'h0, 32'h0, 1'b0);
      wait_idle("ovf_after", 60);
      check("ovf_flag_clear", rx_at(1), 8'h03);
      check("ovf_drop_kept", drop_cnt_o, 2);

      // Reset mid-frame at byte 5 with another record queued.
      rx_start = rx_q.size();
      push_rec(32'h0000_0400, 32'h0000_0023, 5'd9, 32'h0000_0099, 32'h0000_0010, 32'h0000_0020, 1'b1);
      push_rec(32'h0000_0404, 32'h0000_0023, 5'd9, 32'h0000_0098, 32'h0000_0014, 32'h0000_0024, 1'b1);
      cnt = 0;
      while (rx_n() < 5 && cnt < 50) begin
         step();
         cnt++;
      end
      check("mid_level_pre", fifo_level_o, 1);
      rst_i = 1'b1;
      step();
      check("mid_valid", tx_valid_o, 0);
      check("mid_level", fifo_level_o, 0);
      check("mid_drop", drop_cnt_o, 0);
      check("mid_busy", busy_o, 0);
      rst_i = 1'b0;
      step();
      check("mid_idle_valid", tx_valid_o, 0);
      rx_start = rx_q.size();
      push_rec(32'h0000_0500, 32'h0000_0093, 5'd6, 32'h0000_0055, 32'h0, 32'h0, 1'b0);
      step();
      check("fresh_valid", tx_valid_o, 1);
      check("fresh_sync", tx_data_o, 8'hA5);
      wait_idle("fresh", 60);
      e = make_frame(32'h0000_0500, 32'h0000_0093, 5'd6, 32'h0000_0055, 32'h0, 32'h0, 1'b0, 1'b0);
      cmp_frame("fresh", e);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
